// File: rtl/instr_mem_dp.sv
// instr_mem_dp: dual-port instruction memory.
//   Fetch port (f_*): 1-cycle read latency, reports misaligned/out-of-range
//   addresses through f_err with f_dout forced to zero.
//   Load port (w_*): byte-enabled write, rejected addresses flagged on w_err
//   for one cycle.
//   After reset release, an optional clear engine zeroes every word, one per
//   cycle, while busy is high; all requests are ignored during that time.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   f_en, f_addr      fetch request and byte address
//   f_dout, f_valid,  fetched word, result valid, bad-address flag
//   f_err
//   w_en, w_be,       write request, byte enables, byte address, data
//   w_addr, w_di
//   w_err             registered write-reject flag
//   busy              clear in progress
module instr_mem_dp #(
    parameter int INSTR_WIDTH    = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH          = 64,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     f_en,
    input  logic [ADDR_WIDTH-1:0]    f_addr,
    output logic [INSTR_WIDTH-1:0]   f_dout,
    output logic                     f_valid,
    output logic                     f_err,
    input  logic                     w_en,
    input  logic [INSTR_WIDTH/8-1:0] w_be,
    input  logic [ADDR_WIDTH-1:0]    w_addr,
    input  logic [INSTR_WIDTH-1:0]   w_di,
    output logic                     w_err,
    output logic                     busy
);
    localparam int NB = INSTR_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]             state;
    logic [IW-1:0]          clr_cnt;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    // Full-width range compare: any set upper address bit makes the access
    // bad, so a large address never aliases onto a low word.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < ADDR_WIDTH'(DEPTH));
    endfunction

    logic                   f_ok, w_ok, f_acc, w_acc, w_do;
    logic [IW-1:0]          f_idx, w_idx;
    logic [INSTR_WIDTH-1:0] wmask, f_old, f_rdata;

    assign busy  = (state == ST_CLEAR);
    assign f_ok  = addr_ok(f_addr);
    assign w_ok  = addr_ok(w_addr);
    assign f_idx = f_addr[IW+1:2];
    assign w_idx = w_addr[IW+1:2];
    assign f_acc = f_en && !busy;
    assign w_acc = w_en && !busy;
    assign w_do  = w_acc && w_ok;

    always_comb begin
        wmask = '0;
        for (int k = 0; k < NB; k++)
            wmask[8*k +: 8] = {8{w_be[k]}};
    end

    // Read-during-write: with bypass the fetch sees the post-write word,
    // built by merging the enabled bytes of w_di into the stored word.
    assign f_old   = mem[f_idx];
    assign f_rdata = (BYPASS != 0 && w_do && (w_idx == f_idx))
                     ? ((f_old & ~wmask) | (w_di & wmask))
                     : f_old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
            f_dout  <= '0;
            f_valid <= 1'b0;
            f_err   <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            f_valid <= f_acc;
            f_err   <= f_acc && !f_ok;
            w_err   <= w_acc && !w_ok;
            if (f_acc)
                f_dout <= f_ok ? f_rdata : '0;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == IW'(DEPTH - 1))
                    state <= ST_IDLE;
            end
        end
    end

    // Storage has no reset; the clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_cnt] <= '0;
        else if (w_do)
            mem[w_idx] <= (mem[w_idx] & ~wmask) | (w_di & wmask);
    end

endmodule

// File: tb/tb_instr_mem_dp.sv
module tb_instr_mem_dp;
    localparam int TB_BYPASS = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_en, w_en;
    logic [31:0] f_addr, w_addr, w_di, f_dout;
    logic [3:0]  w_be;
    logic        f_valid, f_err, w_err, busy;

    instr_mem_dp #(.INSTR_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64),
                   .BYPASS(TB_BYPASS), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_en(f_en), .f_addr(f_addr), .f_dout(f_dout), .f_valid(f_valid), .f_err(f_err),
        .w_en(w_en), .w_be(w_be), .w_addr(w_addr), .w_di(w_di), .w_err(w_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        fe;
        logic [31:0] fa;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_fe;
        logic        exp_we;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic fe, input logic [31:0] fa, input logic we,
                       input logic [3:0] be, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] ed, input logic efe, input logic ewe);
        vec_t v;
        v.fe = fe; v.fa = fa; v.we = we; v.be = be; v.wa = wa; v.wd = wd;
        v.exp_d = ed; v.exp_fe = efe; v.exp_we = ewe;
        vt.push_back(v);
    endtask

    // Scoreboard: every fetch result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && f_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fvalid actual=%h expected=none", f_dout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_dout", f_dout, e.d);
                chk("sb_err", {31'b0, f_err}, {31'b0, e.e});
            end
        end
    end

    // Counts edges with busy high after release; also pokes both ports
    // mid-clear and expects them to be ignored.
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            if (n == 5) begin
                f_en = 1; f_addr = 32'h0;
                w_en = 1; w_addr = 32'h0; w_be = 4'hF; w_di = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
            n++;
            if (n == 6) begin
                chk({name, "_busy_fvalid"}, {31'b0, f_valid}, 32'd0);
                chk({name, "_busy_werr"}, {31'b0, w_err}, 32'd0);
                f_en = 0; w_en = 0;
            end
        end
        chk({name, "_busy_len"}, n, 32'd64);
    endtask

    initial begin
        logic [31:0] last_d;
        rst_n = 0; f_en = 0; w_en = 0; f_addr = 0; w_addr = 0; w_be = 0; w_di = 0;
        #12;
        chk("rst_fdout", f_dout, 0);
        chk("rst_fvalid", {31'b0, f_valid}, 0);
        chk("rst_ferr", {31'b0, f_err}, 0);
        chk("rst_werr", {31'b0, w_err}, 0);
        chk("rst_busy", {31'b0, busy}, 1);
        @(posedge clk); #1; rst_n = 1;
        wait_clear("clr1");

        //  fe fa             we be    wa             wd             exp_d          efe ewe
        add(1, 32'h0,         0, 4'h0, 32'h0,         32'h0,         32'h0,         0, 0);
        add(1, 32'h10,        0, 4'h0, 32'h0,         32'h0,         32'h0,         0, 0);
        add(0, 32'h0,         1, 4'hF, 32'h0,         32'h4321_DCBA, 32'h0,         0, 0);
        add(0, 32'h0,         1, 4'hF, 32'h4,         32'hFFFF_FFFF, 32'h0,         0, 0);
        add(1, 32'h0,         0, 4'h0, 32'h0,         32'h0,         32'h4321_DCBA, 0, 0);
        add(1, 32'h4,         0, 4'h0, 32'h0,         32'h0,         32'hFFFF_FFFF, 0, 0);
        add(0, 32'h0,         1, 4'h5, 32'h0,         32'h1122_3344, 32'h0,         0, 0);
        add(1, 32'h0,         0, 4'h0, 32'h0,         32'h0,         32'h4322_DC44, 0, 0);
        add(1, 32'h6,         0, 4'h0, 32'h0,         32'h0,         32'h0,         1, 0);
        add(0, 32'h0,         1, 4'hF, 32'h100,       32'hDEAD_BEEF, 32'h0,         0, 1);
        add(1, 32'h0,         0, 4'h0, 32'h0,         32'h0,         32'h4322_DC44, 0, 0);
        add(1, 32'h8,         1, 4'hF, 32'h8,         32'hA5A5_A5A5,
            (TB_BYPASS != 0) ? 32'hA5A5_A5A5 : 32'h0,                               0, 0);
        add(1, 32'h8,         0, 4'h0, 32'h0,         32'h0,         32'hA5A5_A5A5, 0, 0);
        add(1, 32'h4,         1, 4'hF, 32'h7,         32'h1234_5678, 32'hFFFF_FFFF, 0, 1);
        add(1, 32'hFC,        0, 4'h0, 32'h0,         32'h0,         32'h0,         0, 0);
        add(1, 32'h100,       0, 4'h0, 32'h0,         32'h0,         32'h0,         1, 0);
        add(1, 32'h8000_0000, 0, 4'h0, 32'h0,         32'h0,         32'h0,         1, 0);
        add(0, 32'h0,         1, 4'hF, 32'h8000_0004, 32'h0BAD_0BAD, 32'h0,         0, 1);
        add(1, 32'h4,         0, 4'h0, 32'h0,         32'h0,         32'hFFFF_FFFF, 0, 0);
        add(0, 32'h0,         1, 4'h0, 32'hC,         32'h1234_5678, 32'h0,         0, 0);
        add(1, 32'hC,         0, 4'h0, 32'h0,         32'h0,         32'h0,         0, 0);
        add(1, 32'h14,        1, 4'hF, 32'h10,        32'hCAFE_F00D, 32'h0,         0, 0);
        add(1, 32'h10,        0, 4'h0, 32'h0,         32'h0,         32'hCAFE_F00D, 0, 0);
        add(0, 32'h0,         0, 4'h0, 32'h0,         32'h0,         32'h0,         0, 0);

        last_d = 32'h0;
        for (int i = 0; i < vt.size(); i++) begin
            f_en = vt[i].fe; f_addr = vt[i].fa;
            w_en = vt[i].we; w_be = vt[i].be; w_addr = vt[i].wa; w_di = vt[i].wd;
            if (vt[i].fe) begin
                exp_t e;
                e.d = vt[i].exp_d; e.e = vt[i].exp_fe;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_fvalid", i), {31'b0, f_valid}, {31'b0, vt[i].fe});
            chk($sformatf("v%0d_werr", i), {31'b0, w_err}, {31'b0, vt[i].exp_we});
            if (!vt[i].fe)
                chk($sformatf("v%0d_fdout_hold", i), f_dout, last_d);
            else
                last_d = vt[i].exp_fe ? 32'h0 : vt[i].exp_d;
        end
        f_en = 0; w_en = 0;

        // Asynchronous reset while outputs are non-zero.
        f_en = 1; f_addr = 32'h10; w_en = 1; w_addr = 32'h100; w_be = 4'hF;
        begin
            exp_t e;
            e.d = 32'hCAFE_F00D; e.e = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        f_en = 0; w_en = 0;
        chk("pre_rst_werr", {31'b0, w_err}, 1);
        @(negedge clk); #1;
        rst_n = 0; #1;
        chk("arst_fdout", f_dout, 0);
        chk("arst_fvalid", {31'b0, f_valid}, 0);
        chk("arst_werr", {31'b0, w_err}, 0);
        chk("arst_busy", {31'b0, busy}, 1);
        @(posedge clk); #1; rst_n = 1;

        // Reset 20 cycles into the clear, then a full clear must follow.
        repeat (20) @(posedge clk);
        #3;
        rst_n = 0; #1;
        chk("mid_rst_busy", {31'b0, busy}, 1);
        chk("mid_rst_fvalid", {31'b0, f_valid}, 0);
        chk("mid_rst_fdout", f_dout, 0);
        @(posedge clk); #1; rst_n = 1;
        wait_clear("clr2");

        for (int i = 0; i < 64; i++) begin
            exp_t e;
            f_en = 1; f_addr = i * 4;
            e.d = 32'h0; e.e = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        f_en = 0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
